// File: rtl/matrix_seq_pkg.sv
// ---------------------------------------------------------------------------
// matrix_seq_pkg
// Shared definitions for the matrix operation sequencer:
//   - FSM state encoding (seq_state_t)
//   - debug_state codes and a helper mapping state -> code
//   - bit positions of the HPS data_in / data_out words
//   - opcode constants, including OP_ILLEGAL which forces the ERROR path
// ---------------------------------------------------------------------------
package matrix_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_SEND  = 3'd4,
    ST_ERROR = 3'd5
  } seq_state_t;

  localparam logic [3:0] DBG_IDLE  = 4'b0001;
  localparam logic [3:0] DBG_LOAD  = 4'b0010;
  localparam logic [3:0] DBG_ALU   = 4'b0100;  // shared by ISSUE and WAIT
  localparam logic [3:0] DBG_SEND  = 4'b1000;
  localparam logic [3:0] DBG_ERROR = 4'b1111;

  // data_in field positions
  localparam int DIN_READY_BIT = 31;
  localparam int DIN_START_BIT = 30;
  localparam int DIN_OP_MSB    = 29;
  localparam int DIN_OP_LSB    = 27;

  // data_out field positions
  localparam int DOUT_ERROR_BIT = 9;
  localparam int DOUT_ACK_BIT   = 8;

  // Opcodes are passed to the ALU untouched; only OP_ILLEGAL is interpreted.
  localparam logic [2:0] OP_ADD     = 3'b000;
  localparam logic [2:0] OP_ILLEGAL = 3'b111;

  function automatic logic [3:0] debug_code(input seq_state_t s);
    logic [3:0] code;
    case (s)
      ST_IDLE:           code = DBG_IDLE;
      ST_LOAD:           code = DBG_LOAD;
      ST_ISSUE, ST_WAIT: code = DBG_ALU;
      ST_SEND:           code = DBG_SEND;
      ST_ERROR:          code = DBG_ERROR;
      default:           code = DBG_IDLE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/matrix_op_sequencer_if.sv
// ---------------------------------------------------------------------------
// matrix_op_sequencer_if
// Bundles the HPS PIO words and the ALU start/done bus of the sequencer.
//   data_in     HPS -> seq  [31] ready strobe, [30] start, [29:27] opcode, [7:0] byte
//   data_out    seq -> HPS  [9] error, [8] fpga_ack, [7:0] result byte
//   alu_start   seq -> ALU  one-cycle issue pulse
//   alu_op      seq -> ALU  opcode held for the whole block
//   alu_a/b     seq -> ALU  operands, valid with alu_start
//   alu_done    ALU -> seq  one-cycle completion pulse
//   alu_result  ALU -> seq  valid with alu_done
//   debug_state seq -> env  state code
// Modports: master = sequencer side, slave = HPS/ALU environment side.
// ---------------------------------------------------------------------------
interface matrix_op_sequencer_if #(
  parameter int DATA_W = 8
);
  logic [31:0]       data_in;
  logic [31:0]       data_out;
  logic              alu_start;
  logic [2:0]        alu_op;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic              alu_done;
  logic [DATA_W-1:0] alu_result;
  logic [3:0]        debug_state;

  modport master (
    input  data_in, alu_done, alu_result,
    output data_out, alu_start, alu_op, alu_a, alu_b, debug_state
  );

  modport slave (
    output data_in, alu_done, alu_result,
    input  data_out, alu_start, alu_op, alu_a, alu_b, debug_state
  );
endinterface

// File: rtl/hps_strobe_sync.sv
// ---------------------------------------------------------------------------
// hps_strobe_sync
// Three-flop chain for an asynchronous HPS control bit. The first two flops
// form the synchronizer; the third only remembers the previous synced value
// so a rising edge can be detected.
//   clk    in   system clock
//   reset  in   asynchronous, active-low reset
//   din    in   raw HPS bit
//   level  out  synchronized level
//   rise   out  one-cycle pulse on a synchronized 0->1 transition
// ---------------------------------------------------------------------------
module hps_strobe_sync (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise
);

  logic [2:0] sync_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[1:0], din};
    end
  end

  assign level = sync_reg[1];
  assign rise  = sync_reg[1] & ~sync_reg[2];

endmodule

// File: rtl/matrix_op_sequencer.sv
// ---------------------------------------------------------------------------
// matrix_op_sequencer
// Loads 2*N_OPS operand bytes from the HPS, issues N_OPS element-wise ALU
// operations (element i with element i+N_OPS), buffers the results and
// streams them back to the HPS. Opcode 3'b111 goes straight to ERROR.
//   clk    in   system clock
//   reset  in   asynchronous, active-low reset
//   bus    matrix_op_sequencer_if.master (HPS words + ALU handshake)
// Build option: define MATRIX_SEQ_TIMEOUT_EN to add a WAIT watchdog that
// moves to ERROR after TIMEOUT_CYCLES cycles without alu_done.
// N_OPS must be a power of two, at least 2.
// ---------------------------------------------------------------------------
module matrix_op_sequencer
  import matrix_seq_pkg::*;
#(
  parameter int DATA_W         = 8,
  parameter int N_OPS          = 8,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                  clk,
  input  logic                  reset,
  matrix_op_sequencer_if.master bus
);

  localparam int BUF_DEPTH = 2 * N_OPS;
  localparam int IDX_W     = $clog2(BUF_DEPTH);
  localparam int OP_W      = $clog2(N_OPS);
  localparam logic [IDX_W-1:0] LAST_LOAD = IDX_W'(BUF_DEPTH - 1);
  localparam logic [IDX_W-1:0] LAST_OP   = IDX_W'(N_OPS - 1);
  localparam logic [IDX_W-1:0] OP_OFFSET = IDX_W'(N_OPS);

  // ---------------- HPS control synchronizers ----------------
  logic ready_level, ready_rise;
  logic start_level, start_rise_unused;

  hps_strobe_sync u_ready_sync (
    .clk   (clk),
    .reset (reset),
    .din   (bus.data_in[DIN_READY_BIT]),
    .level (ready_level),
    .rise  (ready_rise)
  );

  // start is level-qualified in IDLE, so its edge output is not needed
  hps_strobe_sync u_start_sync (
    .clk   (clk),
    .reset (reset),
    .din   (bus.data_in[DIN_START_BIT]),
    .level (start_level),
    .rise  (start_rise_unused)
  );

  logic [2:0]        din_opcode;
  logic [DATA_W-1:0] din_byte;
  logic [26-DATA_W:0] din_unused;
  assign din_opcode = bus.data_in[DIN_OP_MSB:DIN_OP_LSB];
  assign din_byte   = bus.data_in[DATA_W-1:0];
  assign din_unused = bus.data_in[26:DATA_W];

  // ---------------- state and datapath registers ----------------
  seq_state_t        state_reg, state_next;
  logic [IDX_W-1:0]  idx_reg;
  logic [DATA_W-1:0] opnd_mem [BUF_DEPTH];
  logic [DATA_W-1:0] res_mem  [N_OPS];
  logic              ack_reg;
  logic [2:0]        op_reg;
  logic              wd_expired;

`ifdef MATRIX_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt_reg;

  // Counter restarts on every issue; expiry fires on the TIMEOUT_CYCLES-th
  // WAIT cycle so ERROR is entered exactly TIMEOUT_CYCLES edges after WAIT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_cnt_reg <= '0;
    end else if (state_reg == ST_ISSUE) begin
      wd_cnt_reg <= '0;
    end else if (state_reg == ST_WAIT && !bus.alu_done) begin
      wd_cnt_reg <= wd_cnt_reg + 1'b1;
    end
  end

  assign wd_expired = (state_reg == ST_WAIT) && (wd_cnt_reg == WD_W'(TIMEOUT_CYCLES - 1));
`else
  // Watchdog not built: WAIT lasts until the ALU answers.
  localparam int TIMEOUT_UNUSED = TIMEOUT_CYCLES;
  assign wd_expired = 1'b0;
`endif

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------- FSM: next-state logic ----------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start_level) begin
          state_next = (din_opcode == OP_ILLEGAL) ? ST_ERROR : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (ready_rise && idx_reg == LAST_LOAD) state_next = ST_ISSUE;
      end
      ST_ISSUE: state_next = ST_WAIT;
      ST_WAIT: begin
        if (bus.alu_done) begin
          state_next = (idx_reg == LAST_OP) ? ST_SEND : ST_ISSUE;
        end else if (wd_expired) begin
          state_next = ST_ERROR;
        end
      end
      ST_SEND: begin
        if (ready_rise && idx_reg == LAST_OP) state_next = ST_IDLE;
      end
      ST_ERROR: begin
        if (ready_rise) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // ---------------- datapath: index, buffers, opcode, ack ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_reg <= '0;
      op_reg  <= '0;
      ack_reg <= 1'b0;
      for (int i = 0; i < BUF_DEPTH; i++) opnd_mem[i] <= '0;
      for (int i = 0; i < N_OPS; i++)     res_mem[i]  <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          idx_reg <= '0;
          if (start_level) op_reg <= din_opcode;
        end
        ST_LOAD: begin
          if (ready_rise) begin
            opnd_mem[idx_reg] <= din_byte;
            idx_reg <= (idx_reg == LAST_LOAD) ? '0 : idx_reg + 1'b1;
          end
        end
        ST_WAIT: begin
          if (bus.alu_done) begin
            res_mem[idx_reg[OP_W-1:0]] <= bus.alu_result;
            idx_reg <= (idx_reg == LAST_OP) ? '0 : idx_reg + 1'b1;
          end
        end
        ST_SEND: begin
          if (ready_rise) idx_reg <= (idx_reg == LAST_OP) ? '0 : idx_reg + 1'b1;
        end
        ST_ERROR: idx_reg <= '0;
        default: ;
      endcase

      // Four-phase ack: only LOAD and SEND accept strobes; the ack drops
      // once the synchronized ready has gone low again.
      if (ready_rise && (state_reg == ST_LOAD || state_reg == ST_SEND)) begin
        ack_reg <= 1'b1;
      end else if (!ready_level) begin
        ack_reg <= 1'b0;
      end
    end
  end

  // ---------------- FSM: output logic ----------------
  logic              issue_start;
  logic [DATA_W-1:0] issue_a, issue_b, send_byte;
  logic              error_flag;
  logic [31:0]       data_out_next;

  always_comb begin
    issue_start = 1'b0;
    issue_a     = '0;
    issue_b     = '0;
    send_byte   = '0;
    error_flag  = 1'b0;
    case (state_reg)
      ST_ISSUE: begin
        issue_start = 1'b1;
        issue_a     = opnd_mem[idx_reg];
        issue_b     = opnd_mem[idx_reg + OP_OFFSET];
      end
      ST_SEND:  send_byte  = res_mem[idx_reg[OP_W-1:0]];
      ST_ERROR: error_flag = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    data_out_next                 = '0;
    data_out_next[DOUT_ERROR_BIT] = error_flag;
    data_out_next[DOUT_ACK_BIT]   = ack_reg;
    data_out_next[DATA_W-1:0]     = send_byte;
  end

  assign bus.data_out    = data_out_next;
  assign bus.alu_start   = issue_start;
  assign bus.alu_a       = issue_a;
  assign bus.alu_b       = issue_b;
  assign bus.alu_op      = op_reg;
  assign bus.debug_state = debug_code(state_reg);

endmodule

// File: tb/tb_matrix_op_sequencer.sv
// ---------------------------------------------------------------------------
// tb_matrix_op_sequencer
// Drives HPS transfers and an ALU responder with randomized operands,
// opcodes and latencies; expected results come from an element-wise model.
// ---------------------------------------------------------------------------
module tb_matrix_op_sequencer;

  localparam int TO = 1023;

  logic clk;
  logic reset;
  logic [31:0] din;
  logic        alu_done_r;
  logic [7:0]  alu_res_r;

  matrix_op_sequencer_if #(.DATA_W(8)) bus ();

  assign bus.data_in    = din;
  assign bus.alu_done   = alu_done_r;
  assign bus.alu_result = alu_res_r;

  matrix_op_sequencer #(.DATA_W(8), .N_OPS(8), .TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // ALU responder control / scoreboard
  logic [7:0] exp_a_q[$];
  logic [7:0] exp_b_q[$];
  logic [2:0] exp_op;
  int         alu_lat = 1;
  bit         alu_hang = 0;
  bit         spur_req = 0;
  int         alu_starts = 0;
  int         last_start_cyc = 0;

  logic [7:0] blk [16];
  logic [7:0] exp_res [8];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] ref_alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: begin p = a * b; return p[7:0]; end
      default: return (a > b) ? a : b;
    endcase
  endfunction

  // ALU model: latency alu_lat cycles from the alu_start cycle to alu_done.
  initial begin
    bit         pend;
    int         left;
    logic [7:0] val;
    logic [7:0] ea, eb;
    pend = 0; left = 0; val = '0;
    alu_done_r = 1'b0;
    alu_res_r  = '0;
    forever begin
      @(negedge clk);
      alu_done_r = 1'b0;
      if (spur_req) begin
        alu_done_r = 1'b1;
        alu_res_r  = 8'hEE;
        spur_req   = 0;
      end
      if (pend) begin
        left--;
        if (left == 0) begin
          alu_done_r = 1'b1;
          alu_res_r  = val;
          pend       = 0;
        end
      end
      if (reset && bus.alu_start) begin
        alu_starts++;
        last_start_cyc = cyc;
        check_val("alu_start_expected", 32'(exp_a_q.size() != 0), 32'd1);
        if (exp_a_q.size() != 0) begin
          ea = exp_a_q.pop_front();
          eb = exp_b_q.pop_front();
          check_val("alu_a", bus.alu_a, ea);
          check_val("alu_b", bus.alu_b, eb);
          check_val("alu_op", bus.alu_op, exp_op);
        end
        val = ref_alu(bus.alu_op, bus.alu_a, bus.alu_b);
        $display("alu  op=%0d a=%02h b=%02h r=%02h", bus.alu_op, bus.alu_a, bus.alu_b, val);
        if (!alu_hang) begin
          pend = 1;
          left = alu_lat;
        end
      end
    end
  end

  // Start request: LOAD/ERROR must appear exactly two edges after first sample.
  task automatic hps_start(input logic [2:0] op, input logic [3:0] exp_dbg);
    din[30]    = 1'b1;
    din[29:27] = op;
    @(negedge clk);
    @(negedge clk);
    check_val("start_early", bus.debug_state, 4'b0001);
    @(negedge clk);
    check_val("start_state", bus.debug_state, exp_dbg);
    din[30] = 1'b0;
    $display("start op=%0d state=%b", op, bus.debug_state);
  endtask

  // One four-phase strobe transfer with exact ack latency.
  task automatic hps_xfer(input logic [7:0] b, input logic exp_ack, input string tag);
    logic got;
    din[31]  = 1'b1;
    din[7:0] = b;
    @(negedge clk);
    @(negedge clk);
    check_val({tag, "_ack_early"}, bus.data_out[8], 1'b0);
    @(negedge clk);
    got = bus.data_out[8];
    check_val({tag, "_ack"}, got, exp_ack);
    din[31] = 1'b0;
    repeat (3) @(negedge clk);
    check_val({tag, "_ack_clr"}, bus.data_out[8], 1'b0);
    $display("xfer %s byte=%02h ack=%0b", tag, b, got);
  endtask

  task automatic wait_dbg(input logic [3:0] code, input int budget, input string tag);
    int n;
    n = 0;
    while (bus.debug_state != code && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_val(tag, bus.debug_state, code);
  endtask

  task automatic run_block(input logic [2:0] op, input int lat, input bit poke);
    alu_lat    = lat;
    alu_starts = 0;
    exp_op     = op;
    for (int i = 0; i < 8; i++) begin
      exp_a_q.push_back(blk[i]);
      exp_b_q.push_back(blk[i+8]);
      exp_res[i] = ref_alu(op, blk[i], blk[i+8]);
    end
    hps_start(op, 4'b0010);
    for (int i = 0; i < 16; i++) hps_xfer(blk[i], 1'b1, "load");
    if (poke) begin
      hps_xfer(8'h5A, 1'b0, "wait_strobe");
      check_val("wait_state", bus.debug_state, 4'b0100);
    end
    wait_dbg(4'b1000, 600, "reach_send");
    if (poke) begin
      din[30]    = 1'b1;
      din[29:27] = 3'b111;
      spur_req   = 1;
      repeat (4) @(negedge clk);
      check_val("send_start_state", bus.debug_state, 4'b1000);
      check_val("send_start_ack", bus.data_out[8], 1'b0);
      din[30]    = 1'b0;
      din[29:27] = op;
      repeat (3) @(negedge clk);
      check_val("send_start_state2", bus.debug_state, 4'b1000);
    end
    check_val("alu_starts", alu_starts, 8);
    for (int i = 0; i < 8; i++) begin
      check_val("send_res", bus.data_out[7:0], exp_res[i]);
      check_val("send_err", bus.data_out[9], 1'b0);
      hps_xfer(8'h00, 1'b1, "send");
    end
    check_val("block_idle", bus.debug_state, 4'b0001);
    $display("block op=%0d lat=%0d poke=%0b done", op, lat, poke);
  endtask

  task automatic rand_fill();
    for (int i = 0; i < 16; i++) blk[i] = 8'($urandom_range(0, 255));
  endtask

  initial begin
    int t_err;
    din        = '0;
    reset      = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values
    check_val("rst_data_out", bus.data_out, 32'h0);
    check_val("rst_debug", bus.debug_state, 4'b0001);
    check_val("rst_alu_start", bus.alu_start, 1'b0);
    check_val("rst_alu_op", bus.alu_op, 3'b000);
    check_val("rst_alu_ab", {bus.alu_a, bus.alu_b}, 16'h0);
    reset = 1'b1;
    @(negedge clk);

    // Reset in the middle of a load
    hps_start(3'b000, 4'b0010);
    for (int i = 0; i < 5; i++) hps_xfer(8'(i + 1), 1'b1, "load_pre");
    reset = 1'b0;
    #1;
    check_val("midrst_data_out", bus.data_out, 32'h0);
    check_val("midrst_debug", bus.debug_state, 4'b0001);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Bytes 1..16, add, latency 3 -> 10,12,...,24
    for (int i = 0; i < 16; i++) blk[i] = 8'(i + 1);
    run_block(3'b000, 3, 0);

    // Overflow wraps: 0xFF + 0x01 -> 0x00
    for (int i = 0; i < 8; i++) begin
      blk[i]   = 8'hFF;
      blk[i+8] = (i == 0) ? 8'h01 : 8'(i);
    end
    run_block(3'b000, 1, 0);

    // Randomized blocks; two of them poke the ignored-event paths
    for (int k = 0; k < 6; k++) begin
      rand_fill();
      run_block(3'($urandom_range(0, 6)), (k == 2 || k == 4) ? 8 : int'($urandom_range(1, 4)), (k == 2 || k == 4));
    end

    // Strobe in IDLE: no ack, stays IDLE
    hps_xfer(8'h44, 1'b0, "idle_strobe");
    check_val("idle_strobe_state", bus.debug_state, 4'b0001);

    // Illegal opcode
    hps_start(3'b111, 4'b1111);
    check_val("err_data_out", bus.data_out, 32'h0000_0200);
    check_val("err_alu_op", bus.alu_op, 3'b111);
    hps_xfer(8'h33, 1'b0, "err_strobe");
    check_val("err_exit_state", bus.debug_state, 4'b0001);
    check_val("err_exit_data_out", bus.data_out, 32'h0);

    // ALU never answers
    rand_fill();
    alu_hang   = 1;
    alu_starts = 0;
    exp_op     = 3'b010;
    for (int i = 0; i < 8; i++) begin
      exp_a_q.push_back(blk[i]);
      exp_b_q.push_back(blk[i+8]);
    end
    hps_start(3'b010, 4'b0010);
    for (int i = 0; i < 16; i++) hps_xfer(blk[i], 1'b1, "hang_load");
`ifdef MATRIX_SEQ_TIMEOUT_EN
    wait_dbg(4'b1111, TO + 100, "timeout_error");
    t_err = cyc;
    // first ERROR negedge is TO+1 posedges after the ISSUE-cycle sample
    check_val("timeout_cycles", t_err - last_start_cyc, TO + 1);
    check_val("timeout_err_bit", bus.data_out[9], 1'b1);
    check_val("timeout_no_restart", alu_starts, 1);
    hps_xfer(8'h00, 1'b0, "timeout_clear");
    check_val("timeout_idle", bus.debug_state, 4'b0001);
`else
    t_err = 0;
    repeat (TO + 50) @(negedge clk);
    check_val("hang_stays_wait", bus.debug_state, 4'b0100);
    check_val("hang_no_error", bus.data_out[9], 1'b0);
    check_val("hang_one_start", alu_starts + t_err, 1);
    reset = 1'b0;
    #1;
    check_val("hang_rst_debug", bus.debug_state, 4'b0001);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
`endif
    alu_hang = 0;
    exp_a_q.delete();
    exp_b_q.delete();

    // Clean block after recovery
    rand_fill();
    run_block(3'($urandom_range(0, 6)), 2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global guard so the run always ends on its own
  initial begin
    #2000000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "bench time limit");
  end

endmodule

// File: doc/matrix_op_sequencer.md
# matrix_op_sequencer

Sequencer between the HPS PIO word interface and a shared 8-bit matrix ALU. Receives a 16-byte operand block from the HPS over a four-phase strobe/ack handshake, issues eight element-wise operations (element i with element i+8) to the ALU over a start/done handshake, buffers the eight results, and streams them back to the HPS. It replaces fixed-function processing with an opcode-driven, ALU-agnostic controller and adds a watchdog/error path.

## Interface
- DATA_W, 8: operand/result byte width
- N_OPS, 8: operations per block; operand buffer holds 2*N_OPS bytes
- TIMEOUT_CYCLES, 1023: max cycles in WAIT before ERROR (watchdog builds only)
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- data_in  in  32  HPS word: [31] hps_ready strobe, [30] start, [29:27] opcode, [7:0] byte
- data_out  out  32  [31:10]=0, [9] error, [8] fpga_ack, [7:0] result byte
- alu_start  out  1  one-cycle issue pulse
- alu_op  out  3  opcode latched at start, held for whole block
- alu_a, alu_b  out  DATA_W  operands, valid while alu_start high
- alu_done  in  1  one-cycle completion pulse
- alu_result  in  DATA_W  valid when alu_done high
- debug_state  out  4  state code

## Operation
- data_in[31] and data_in[30] pass through 3-flop synchronizers; strobe event = synced ready rising edge.
- States: IDLE, LOAD, ISSUE, WAIT, SEND, ERROR.
- IDLE: on synced start=1, latch opcode; opcode 3'b111 -> ERROR, else -> LOAD with idx=0.
- LOAD: each strobe event stores data_in[7:0] into buf[idx], sets fpga_ack; after byte 2*N_OPS-1 -> ISSUE, idx=0.
- ISSUE: alu_start=1 for one cycle, alu_a=buf[idx], alu_b=buf[idx+N_OPS] -> WAIT.
- WAIT: on alu_done capture alu_result into res[idx]; idx==N_OPS-1 -> SEND with idx=0, else idx+1 -> ISSUE.
- SEND: data_out[7:0]=res[idx] combinationally; each strobe event sets fpga_ack and advances idx; after N_OPS-th event -> IDLE.
- fpga_ack: four-phase; set on accepted strobe event, cleared when synced hps_ready falls.
- ERROR: error=1, data_out[7:0]=0; strobe event -> IDLE, error cleared, no ack.
- Ignored: start outside IDLE; strobe events in IDLE/ISSUE/WAIT (no ack); alu_done outside WAIT.
- Counters wrap to 0 on transition out; no index exceeds buffer bounds.
- debug_state: IDLE 0001, LOAD 0010, ISSUE/WAIT 0100, SEND 1000, ERROR 1111.

## Timing
- Reset values: data_out=0, alu_start=0, alu_op=0, alu_a=alu_b=0, debug_state=0001; buffers and counters cleared; reset mid-block aborts to IDLE immediately.
- Strobe latency: data_in[31] sampled 1 at edge k -> byte captured and fpga_ack high after edge k+2.
- Start latency: data_in[30] sampled 1 at edge k -> LOAD after edge k+2.
- HPS holds data_in[7:0] stable while hps_ready high.
- ISSUE->alu_start: 1 cycle; alu_done same cycle as alu_start ignored (ALU latency >= 1).
- WAIT->ISSUE on the edge that samples alu_done; sustained rate 1 op per (ALU latency + 1) cycles.
- Last alu_done -> SEND next edge; res[0] on data_out same cycle.

## Configuration
- MATRIX_SEQ_TIMEOUT_EN defined: WAIT cycle counter; reaching TIMEOUT_CYCLES without alu_done -> ERROR, alu_start stays low.
- Undefined: no counter, WAIT indefinite; ERROR reachable only via opcode 3'b111; TIMEOUT_CYCLES unused.

## Structure
- Package matrix_seq_pkg: state encoding, debug_state codes, data_in/data_out bit-position constants, opcode constants incl. OP_ILLEGAL=3'b111.
- Sub-module hps_strobe_sync: 3-flop synchronizer plus rising-edge detect, instantiated for ready and (without edge output) start.

## Test plan
- Reset asserted mid-LOAD after 5 bytes -> data_out=0, debug_state=0001; 16 fresh bytes then load cleanly.
- Start opcode 000, bytes 1..16, ALU model a+b latency 3 -> eight alu_start pulses, SEND yields 10,12,...,24, each with ack.
- Bytes 0xFF,...; model a+b truncated -> 0xFF+0x01 returns 0x00; sequencer passes ALU result unchanged.
- Start opcode 111 -> ERROR, debug_state=1111, error=1; next strobe -> IDLE, error=0, no ack.
- Timeout build, ALU never asserts alu_done -> ERROR exactly TIMEOUT_CYCLES cycles after entering WAIT; non-timeout build stays in WAIT.
- Strobes during WAIT and start pulse during SEND -> no ack, no state change, results intact.
